// File: rtl/register_file_mp_if.sv
// Port bundle for register_file_mp: write port, packed read ports, pending-load
// scoreboard and clear-engine control/status.
interface register_file_mp_if #(
    parameter int unsigned N        = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned RD_PORTS = 2
);
    localparam int unsigned A = $clog2(DEPTH);

    logic                  wr_ena;
    logic [A-1:0]          wr_addr;
    logic [N-1:0]          wr_data;
    logic [RD_PORTS*A-1:0] rd_addr;
    logic [RD_PORTS*N-1:0] rd_data;
    logic [RD_PORTS-1:0]   rd_pending;
    logic                  pend_set;
    logic [A-1:0]          pend_addr;
    logic                  clr_req;
    logic                  clr_busy;
    logic                  clr_done;
    logic                  wr_drop;

    modport master (
        output wr_ena, wr_addr, wr_data, rd_addr, pend_set, pend_addr, clr_req,
        input  rd_data, rd_pending, clr_busy, clr_done, wr_drop
    );

    modport slave (
        input  wr_ena, wr_addr, wr_data, rd_addr, pend_set, pend_addr, clr_req,
        output rd_data, rd_pending, clr_busy, clr_done, wr_drop
    );
endinterface

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file with write-to-read bypass, a pending-load
// scoreboard and a sequential clear engine that zeroes one entry per cycle.
module register_file_mp #(
    parameter int unsigned N        = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned RD_PORTS = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input logic               clk,
    input logic               rst,
    register_file_mp_if.slave bus
);
    localparam int unsigned A  = $clog2(DEPTH);
    // One extra counter bit so DEPTH == 2**A does not wrap before termination.
    localparam int unsigned CW = A + 1;
    localparam logic [CW-1:0] DepthW = CW'(DEPTH);
    localparam logic [CW-1:0] LastW  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] StartW = ZERO_REG ? CW'(1) : CW'(0);

    typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

    logic [N-1:0]     mem_q [DEPTH];
    logic [N-1:0]     mem_d [DEPTH];
    logic [DEPTH-1:0] pend_q, pend_d;
    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             clr_busy_q, clr_busy_d;
    logic             clr_done_q, clr_done_d;
    logic             wr_drop_q, wr_drop_d;

    logic             sweep;
    logic             wr_acc;
    logic             pend_ok;
    logic [A-1:0]     cnt_idx;

    function automatic logic in_range(input logic [A-1:0] a);
        return {1'b0, a} < DepthW;
    endfunction

    function automatic logic is_zero(input logic [A-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    assign sweep   = (state_q == StClear);
    assign cnt_idx = cnt_q[A-1:0];
    assign wr_acc  = bus.wr_ena && !sweep && in_range(bus.wr_addr) && !is_zero(bus.wr_addr);
    assign pend_ok = bus.pend_set && in_range(bus.pend_addr) && !is_zero(bus.pend_addr) &&
                     !(sweep && (bus.pend_addr == cnt_idx));

    always_comb begin
        mem_d      = mem_q;
        pend_d     = pend_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
        wr_drop_d  = bus.wr_ena && sweep;

        if (wr_acc) begin
            mem_d[bus.wr_addr]  = bus.wr_data;
            pend_d[bus.wr_addr] = 1'b0;
        end
        // Set after clear: a newer load outstanding beats the writeback.
        if (pend_ok) begin
            pend_d[bus.pend_addr] = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.clr_req) begin
                    state_d = StClear;
                    cnt_d   = StartW;
                end
            end
            StClear: begin
                mem_d[cnt_idx]  = '0;
                pend_d[cnt_idx] = 1'b0;
                cnt_d           = cnt_q + 1'b1;
                if (cnt_q == LastW) begin
                    state_d    = StDone;
                    clr_done_d = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        clr_busy_d = (state_d == StClear);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q      <= '{default: '0};
            pend_q     <= '0;
            state_q    <= StIdle;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            pend_q     <= pend_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
            wr_drop_q  <= wr_drop_d;
        end
    end

    logic [RD_PORTS*N-1:0] rd_data;
    logic [RD_PORTS-1:0]   rd_pend;
    logic [A-1:0]          ra;

    always_comb begin
        rd_data = '0;
        rd_pend = '0;
        ra      = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            ra = bus.rd_addr[p*A +: A];
            if (in_range(ra) && !is_zero(ra)) begin
                rd_pend[p] = pend_q[ra];
                if (BYPASS && wr_acc && (bus.wr_addr == ra)) begin
                    rd_data[p*N +: N] = bus.wr_data;
                end else begin
                    rd_data[p*N +: N] = mem_q[ra];
                end
            end
        end
    end

    assign bus.rd_data    = rd_data;
    assign bus.rd_pending = rd_pend;
    assign bus.clr_busy   = clr_busy_q;
    assign bus.clr_done   = clr_done_q;
    assign bus.wr_drop    = wr_drop_q;
endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: default, no-bypass and 3-port/20-deep/16-bit instances,
// checked against expectations queued when stimulus is applied.
module tb_register_file_mp;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    register_file_mp_if #(.N(32), .DEPTH(32), .RD_PORTS(2)) bus_a ();
    register_file_mp_if #(.N(32), .DEPTH(32), .RD_PORTS(2)) bus_b ();
    register_file_mp_if #(.N(16), .DEPTH(20), .RD_PORTS(3)) bus_c ();

    register_file_mp #(.N(32), .DEPTH(32), .RD_PORTS(2), .ZERO_REG(1'b1), .BYPASS(1'b1))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    register_file_mp #(.N(32), .DEPTH(32), .RD_PORTS(2), .ZERO_REG(1'b1), .BYPASS(1'b0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    register_file_mp #(.N(16), .DEPTH(20), .RD_PORTS(3), .ZERO_REG(1'b0), .BYPASS(1'b1))
        dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    typedef struct {
        string       name;
        logic [63:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus_a.wr_ena = 0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.rd_addr = '0;
        bus_a.pend_set = 0; bus_a.pend_addr = '0; bus_a.clr_req = 0;
        bus_b.wr_ena = 0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.rd_addr = '0;
        bus_b.pend_set = 0; bus_b.pend_addr = '0; bus_b.clr_req = 0;
        bus_c.wr_ena = 0; bus_c.wr_addr = '0; bus_c.wr_data = '0; bus_c.rd_addr = '0;
        bus_c.pend_set = 0; bus_c.pend_addr = '0; bus_c.clr_req = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_all();
        repeat (2) step();
        rst = 1'b0;
        step();
        sb.push_back('{"reset status", 64'h0});
        @(negedge clk);
        e = sb.pop_front(); total++;
        if (64'({bus_a.clr_busy, bus_a.clr_done, bus_a.wr_drop, bus_a.rd_pending}) !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name,
                {bus_a.clr_busy, bus_a.clr_done, bus_a.wr_drop, bus_a.rd_pending}, e.v);
        end

        step();
        bus_a.wr_ena = 1; bus_a.wr_addr = 5'd5; bus_a.wr_data = 32'h12345678;
        bus_a.rd_addr = {5'd5, 5'd0};
        step();
        bus_a.wr_addr = 5'd0; bus_a.wr_data = 32'hDEADBEEF;
        sb.push_back('{"write addr5 port1", 64'h12345678});
        sb.push_back('{"zero reg no bypass", 64'h0});
        @(negedge clk);
        e = sb.pop_front(); total++;
        if (64'(bus_a.rd_data[63:32]) !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_a.rd_data[63:32], e.v);
        end
        e = sb.pop_front(); total++;
        if (64'(bus_a.rd_data[31:0]) !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_a.rd_data[31:0], e.v);
        end

        step();
        bus_a.wr_ena = 0;
        sb.push_back('{"zero reg after write", 64'h0});
        @(negedge clk);
        e = sb.pop_front(); total++;
        if (64'(bus_a.rd_data[31:0]) !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_a.rd_data[31:0], e.v);
        end

        // Asynchronous reset in the middle of a cycle must clear reads at once.
        @(posedge clk);
        #3 rst = 1'b1;
        sb.push_back('{"async reset read", 64'h0});
        #1;
        e = sb.pop_front(); total++;
        if (bus_a.rd_data !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_a.rd_data, e.v);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_bypass();
        step();
        bus_a.wr_ena = 1; bus_a.wr_addr = 5'd7; bus_a.wr_data = 32'h1; bus_a.rd_addr = {5'd7, 5'd7};
        bus_b.wr_ena = 1; bus_b.wr_addr = 5'd7; bus_b.wr_data = 32'h1; bus_b.rd_addr = {5'd7, 5'd7};
        step();
        bus_a.wr_data = 32'hCAFEF00D;
        bus_b.wr_data = 32'hCAFEF00D;
        sb.push_back('{"bypass on", {32'hCAFEF00D, 32'hCAFEF00D}});
        sb.push_back('{"bypass off same cycle", {32'h1, 32'h1}});
        @(negedge clk);
        e = sb.pop_front(); total++;
        if (bus_a.rd_data !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_a.rd_data, e.v);
        end
        e = sb.pop_front(); total++;
        if (bus_b.rd_data !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_b.rd_data, e.v);
        end
        step();
        bus_a.wr_ena = 0; bus_b.wr_ena = 0;
        sb.push_back('{"bypass off next cycle", {32'hCAFEF00D, 32'hCAFEF00D}});
        @(negedge clk);
        e = sb.pop_front(); total++;
        if (bus_b.rd_data !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_b.rd_data, e.v);
        end
    endtask

    task automatic test_scoreboard();
        step();
        bus_a.pend_set = 1; bus_a.pend_addr = 5'd9; bus_a.rd_addr = {5'd0, 5'd9};
        sb.push_back('{"pend not bypassed", 64'h0});
        @(negedge clk);
        e = sb.pop_front(); total++;
        if (64'(bus_a.rd_pending[0]) !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_a.rd_pending[0], e.v);
        end
        step();
        bus_a.pend_set = 0;
        sb.push_back('{"pend set", 64'h1});
        @(negedge clk);
        e = sb.pop_front(); total++;
        if (64'(bus_a.rd_pending[0]) !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_a.rd_pending[0], e.v);
        end
        step();
        bus_a.wr_ena = 1; bus_a.wr_addr = 5'd9; bus_a.wr_data = 32'h99;
        step();
        bus_a.wr_ena = 0;
        sb.push_back('{"pend cleared by write", 64'h0});
        @(negedge clk);
        e = sb.pop_front(); total++;
        if (64'(bus_a.rd_pending[0]) !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_a.rd_pending[0], e.v);
        end
        step();
        bus_a.wr_ena = 1; bus_a.wr_data = 32'hABCD; bus_a.pend_set = 1;
        step();
        bus_a.wr_ena = 0; bus_a.pend_set = 0;
        sb.push_back('{"pend set wins", 64'h1});
        sb.push_back('{"data with set", 64'hABCD});
        @(negedge clk);
        e = sb.pop_front(); total++;
        if (64'(bus_a.rd_pending[0]) !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_a.rd_pending[0], e.v);
        end
        e = sb.pop_front(); total++;
        if (64'(bus_a.rd_data[31:0]) !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_a.rd_data[31:0], e.v);
        end
        step();
        bus_a.pend_set = 1; bus_a.pend_addr = 5'd0;
        step();
        bus_a.pend_set = 0;
        sb.push_back('{"pend zero reg", 64'h0});
        @(negedge clk);
        e = sb.pop_front(); total++;
        if (64'(bus_a.rd_pending[1]) !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_a.rd_pending[1], e.v);
        end
    endtask

    task automatic test_clear();
        int busy_n = 0;
        int done_n = 0;
        for (int i = 1; i < 32; i++) begin
            step();
            bus_a.wr_ena = 1; bus_a.wr_addr = 5'(i); bus_a.wr_data = 32'(i);
        end
        step();
        bus_a.wr_ena = 0; bus_a.clr_req = 1; bus_a.pend_set = 1; bus_a.pend_addr = 5'd9;
        step();
        bus_a.clr_req = 0; bus_a.pend_set = 0; bus_a.rd_addr = {5'd30, 5'd3};
        for (int cyc = 0; cyc < 100 && done_n == 0; cyc++) begin
            @(negedge clk);
            if (bus_a.clr_busy) busy_n++;
            if (bus_a.clr_done) done_n++;
            if (busy_n == 5 && bus_a.clr_busy) begin
                sb.push_back('{"midway e30 e3", {32'd30, 32'd0}});
                e = sb.pop_front(); total++;
                if (bus_a.rd_data !== e.v) begin
                    bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_a.rd_data, e.v);
                end
            end
        end
        sb.push_back('{"clear busy cycles", 64'd31});
        sb.push_back('{"clear done seen", 64'd1});
        e = sb.pop_front(); total++;
        if (64'(busy_n) !== e.v) begin
            bad++; $display("FAIL %s: got=%0d exp=%0d", e.name, busy_n, e.v);
        end
        e = sb.pop_front(); total++;
        if (64'(done_n) !== e.v) begin
            bad++; $display("FAIL %s: got=%0d exp=%0d", e.name, done_n, e.v);
        end
        #1;
        bus_a.rd_addr = {5'd9, 5'd31};
        sb.push_back('{"done single pulse", 64'h0});
        sb.push_back('{"cleared reads", 64'h0});
        sb.push_back('{"cleared pending", 64'h0});
        @(negedge clk);
        e = sb.pop_front(); total++;
        if (64'({bus_a.clr_done, bus_a.clr_busy}) !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name,
                {bus_a.clr_done, bus_a.clr_busy}, e.v);
        end
        e = sb.pop_front(); total++;
        if (bus_a.rd_data !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_a.rd_data, e.v);
        end
        e = sb.pop_front(); total++;
        if (64'(bus_a.rd_pending) !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_a.rd_pending, e.v);
        end
    endtask

    task automatic test_clear_collisions();
        int busy_n = 0;
        int done_n = 0;
        int drop_n = 0;
        step();
        bus_a.wr_ena = 1; bus_a.wr_addr = 5'd4; bus_a.wr_data = 32'h44;
        step();
        bus_a.wr_addr = 5'd25; bus_a.wr_data = 32'h25;
        step();
        bus_a.wr_ena = 0; bus_a.clr_req = 1;
        step();
        bus_a.clr_req = 0; bus_a.rd_addr = {5'd25, 5'd4};
        for (int cyc = 0; cyc < 100 && done_n == 0; cyc++) begin
            @(negedge clk);
            if (bus_a.wr_drop) drop_n++;
            if (bus_a.clr_busy) busy_n++;
            if (busy_n == 10 && bus_a.clr_busy) begin
                bus_a.wr_ena = 1; bus_a.wr_addr = 5'd4; bus_a.wr_data = 32'h99;
                bus_a.clr_req = 1;
            end else begin
                bus_a.wr_ena = 0; bus_a.clr_req = 0;
            end
            // Request a clear while DONE is showing; it must be ignored.
            if (bus_a.clr_done) begin
                done_n++;
                bus_a.clr_req = 1;
            end
        end
        step();
        bus_a.clr_req = 0;
        sb.push_back('{"collide busy cycles", 64'd31});
        sb.push_back('{"collide drop pulses", 64'd1});
        sb.push_back('{"req in done ignored", 64'h0});
        sb.push_back('{"dropped write e25 e4", 64'h0});
        e = sb.pop_front(); total++;
        if (64'(busy_n) !== e.v) begin
            bad++; $display("FAIL %s: got=%0d exp=%0d", e.name, busy_n, e.v);
        end
        e = sb.pop_front(); total++;
        if (64'(drop_n) !== e.v) begin
            bad++; $display("FAIL %s: got=%0d exp=%0d", e.name, drop_n, e.v);
        end
        @(negedge clk);
        e = sb.pop_front(); total++;
        if (64'(bus_a.clr_busy) !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_a.clr_busy, e.v);
        end
        e = sb.pop_front(); total++;
        if (bus_a.rd_data !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_a.rd_data, e.v);
        end
    endtask

    task automatic test_reset_mid_clear();
        int done_n = 0;
        int busy_n = 0;
        step();
        bus_a.wr_ena = 1; bus_a.wr_addr = 5'd25; bus_a.wr_data = 32'h25;
        step();
        bus_a.wr_ena = 0; bus_a.clr_req = 1;
        step();
        bus_a.clr_req = 0; bus_a.rd_addr = {5'd25, 5'd25};
        repeat (10) @(negedge clk);
        sb.push_back('{"busy before reset", 64'h1});
        e = sb.pop_front(); total++;
        if (64'(bus_a.clr_busy) !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_a.clr_busy, e.v);
        end
        #1 rst = 1'b1;
        sb.push_back('{"reset mid clear data", 64'h0});
        sb.push_back('{"reset mid clear busy", 64'h0});
        #1;
        e = sb.pop_front(); total++;
        if (bus_a.rd_data !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_a.rd_data, e.v);
        end
        e = sb.pop_front(); total++;
        if (64'(bus_a.clr_busy) !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_a.clr_busy, e.v);
        end
        step();
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus_a.clr_done) done_n++;
            if (bus_a.clr_busy) busy_n++;
        end
        sb.push_back('{"no done after abort", 64'h0});
        sb.push_back('{"idle after abort", 64'h0});
        e = sb.pop_front(); total++;
        if (64'(done_n) !== e.v) begin
            bad++; $display("FAIL %s: got=%0d exp=%0d", e.name, done_n, e.v);
        end
        e = sb.pop_front(); total++;
        if (64'(busy_n) !== e.v) begin
            bad++; $display("FAIL %s: got=%0d exp=%0d", e.name, busy_n, e.v);
        end
    endtask

    task automatic test_params();
        int busy_n = 0;
        int done_n = 0;
        step();
        bus_c.wr_ena = 1; bus_c.wr_addr = 5'd0; bus_c.wr_data = 16'hBEEF;
        bus_c.rd_addr = {5'd19, 5'd25, 5'd0};
        step();
        bus_c.wr_addr = 5'd25; bus_c.wr_data = 16'h1234;
        sb.push_back('{"oob write not bypassed", 64'h0});
        @(negedge clk);
        e = sb.pop_front(); total++;
        if (64'(bus_c.rd_data[31:16]) !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_c.rd_data[31:16], e.v);
        end
        step();
        bus_c.wr_addr = 5'd19; bus_c.wr_data = 16'h1919;
        step();
        bus_c.wr_ena = 0; bus_c.pend_set = 1; bus_c.pend_addr = 5'd0;
        step();
        bus_c.pend_set = 0;
        sb.push_back('{"params reads", {16'h0, 16'h1919, 16'h0000, 16'hBEEF}});
        sb.push_back('{"params pend e0", 64'h1});
        @(negedge clk);
        e = sb.pop_front(); total++;
        if (64'(bus_c.rd_data) !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_c.rd_data, e.v);
        end
        e = sb.pop_front(); total++;
        if (64'(bus_c.rd_pending) !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_c.rd_pending, e.v);
        end
        step();
        bus_c.clr_req = 1;
        step();
        bus_c.clr_req = 0;
        for (int cyc = 0; cyc < 100 && done_n == 0; cyc++) begin
            @(negedge clk);
            if (bus_c.clr_busy) busy_n++;
            if (bus_c.clr_done) done_n++;
        end
        step();
        sb.push_back('{"params clear cycles", 64'd20});
        sb.push_back('{"params cleared reads", 64'h0});
        sb.push_back('{"params cleared pend", 64'h0});
        e = sb.pop_front(); total++;
        if (64'(busy_n) !== e.v) begin
            bad++; $display("FAIL %s: got=%0d exp=%0d", e.name, busy_n, e.v);
        end
        @(negedge clk);
        e = sb.pop_front(); total++;
        if (64'(bus_c.rd_data) !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_c.rd_data, e.v);
        end
        e = sb.pop_front(); total++;
        if (64'(bus_c.rd_pending) !== e.v) begin
            bad++; $display("FAIL %s: got=%0h exp=%0h", e.name, bus_c.rd_pending, e.v);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_scoreboard();
        test_clear();
        test_clear_collisions();
        test_reset_mid_clear();
        test_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
